// File: rtl/sd_fifo_pkg.sv
// Shared helpers for the srdy/drdy FIFO family: usage-width function and
// common handshake assertion macros used by both the input- and output-port FIFOs.
`ifndef SD_FIFO_PKG_MACROS
`define SD_FIFO_PKG_MACROS
// Once srdy is raised without drdy, srdy and the payload must hold until taken.
`define SD_ASSERT_HOLD(clk, rstn, srdy, drdy, data) \
    assert property (@(posedge clk) disable iff (!rstn) \
        ((srdy) && !(drdy)) |=> ((srdy) && $stable(data)))
// An occupancy counter never exceeds its capacity.
`define SD_ASSERT_BOUND(clk, rstn, cnt, lim) \
    assert property (@(posedge clk) disable iff (!rstn) ((cnt) <= (lim)))
`endif

package sd_fifo_pkg;

    function automatic int unsigned usage_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sd_fifo_headrd_ctl.sv
// Control for the head-read FIFO: usage counter, registered c_drdy/p_srdy,
// and per-entry write selects plus the shift-toward-head enable.
module sd_fifo_headrd_ctl
    import sd_fifo_pkg::*;
#(
    parameter int unsigned depth = 4,
    parameter int unsigned usz   = usage_width(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    input  logic             p_drdy,
    output logic             c_drdy,
    output logic             p_srdy,
    output logic [usz-1:0]   usage,
    output logic [usz-1:0]   nxt_usage,
    output logic [depth-1:0] wr_sel_c,
    output logic             shift_c
);

    logic           wr;
    logic           rd;
    logic [usz-1:0] wr_idx;

    // On a simultaneous read the queue shifts, so the write lands one slot lower.
    always_comb begin
        wr        = c_srdy & c_drdy;
        rd        = p_srdy & p_drdy;
        nxt_usage = usage + usz'(wr) - usz'(rd);
        wr_idx    = rd ? (usage - usz'(1)) : usage;
        shift_c   = rd;
        wr_sel_c  = '0;
        for (int i = 0; i < int'(depth); i++) begin
            wr_sel_c[i] = wr & (wr_idx == usz'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            usage  <= '0;
            p_srdy <= 1'b0;
            c_drdy <= 1'b1;
        end else begin
            usage  <= nxt_usage;
            p_srdy <= (nxt_usage != '0);
            c_drdy <= (nxt_usage < usz'(depth));
        end
    end

endmodule

// File: rtl/sd_fifo_headrd.sv
// Output-port FIFO: head entry presented from data_buf[0], shifts on every read.
// Optional SD_FIFO_HEADRD_DATA_RESET_EN gives the data flops an async reset to 0.
module sd_fifo_headrd
    import sd_fifo_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4,
    parameter int unsigned usz   = usage_width(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] c_data,
    input  logic             c_srdy,
    output logic             c_drdy,
    output logic [width-1:0] p_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [usz-1:0]   usage,
    output logic [usz-1:0]   nxt_usage
);

    logic [width-1:0] data_buf [depth];
    logic [width-1:0] data_nxt [depth];
    logic [depth-1:0] wr_sel_c;
    logic             shift_c;

    sd_fifo_headrd_ctl #(
        .depth (depth),
        .usz   (usz)
    ) u_ctl (
        .clk       (clk),
        .reset     (reset),
        .c_srdy    (c_srdy),
        .p_drdy    (p_drdy),
        .c_drdy    (c_drdy),
        .p_srdy    (p_srdy),
        .usage     (usage),
        .nxt_usage (nxt_usage),
        .wr_sel_c  (wr_sel_c),
        .shift_c   (shift_c)
    );

    // Shift toward the head on read; the tail slot keeps its value.
    always_comb begin
        for (int i = 0; i < int'(depth) - 1; i++) begin
            data_nxt[i] = shift_c ? data_buf[i+1] : data_buf[i];
        end
        data_nxt[depth-1] = data_buf[depth-1];
        for (int i = 0; i < int'(depth); i++) begin
            if (wr_sel_c[i]) begin
                data_nxt[i] = c_data;
            end
        end
    end

`ifdef SD_FIFO_HEADRD_DATA_RESET_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(depth); i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(depth); i++) begin
                data_buf[i] <= data_nxt[i];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(depth); i++) begin
            data_buf[i] <= data_nxt[i];
        end
    end
`endif

    assign p_data = data_buf[0];

    `SD_ASSERT_HOLD(clk, reset, p_srdy, p_drdy, p_data);
    `SD_ASSERT_BOUND(clk, reset, usage, usz'(depth));

endmodule
